// File: rtl/march_lr_pkg.sv
// March LR encodings: FSM states, elements, ops, per-element op tables, backgrounds.
// Pure definitions; no latency or backpressure of its own.
package march_lr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    E0 = 3'd0,
    E1 = 3'd1,
    E2 = 3'd2,
    E3 = 3'd3,
    E4 = 3'd4,
    E5 = 3'd5
  } elem_t;

  typedef enum logic {
    OP_R = 1'b0,
    OP_W = 1'b1
  } op_kind_t;

  // bg selects the background word: 0 -> D0 (all zeros), 1 -> D1 (all ones)
  typedef struct packed {
    op_kind_t kind;
    logic     bg;
  } op_t;

  localparam logic  BG_D0     = 1'b0;
  localparam logic  BG_D1     = 1'b1;
  localparam elem_t LAST_ELEM = E5;

  function automatic logic elem_down(elem_t e);
    return (e == E1);
  endfunction

  function automatic logic [1:0] elem_last_op(elem_t e);
    case (e)
      E0, E5:  return 2'd0;
      E1, E3:  return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic op_t elem_op(elem_t e, logic [1:0] idx);
    op_t op;
    op = '{kind: OP_R, bg: BG_D0};
    case (e)
      E0: op = '{kind: OP_W, bg: BG_D0};
      E1: case (idx)
            2'd0:    op = '{kind: OP_R, bg: BG_D0};
            default: op = '{kind: OP_W, bg: BG_D1};
          endcase
      E2: case (idx)
            2'd0:    op = '{kind: OP_R, bg: BG_D1};
            2'd1:    op = '{kind: OP_W, bg: BG_D0};
            2'd2:    op = '{kind: OP_R, bg: BG_D0};
            default: op = '{kind: OP_W, bg: BG_D1};
          endcase
      E3: case (idx)
            2'd0:    op = '{kind: OP_R, bg: BG_D1};
            default: op = '{kind: OP_W, bg: BG_D0};
          endcase
      E4: case (idx)
            2'd0:    op = '{kind: OP_R, bg: BG_D0};
            2'd1:    op = '{kind: OP_W, bg: BG_D1};
            2'd2:    op = '{kind: OP_R, bg: BG_D1};
            default: op = '{kind: OP_W, bg: BG_D0};
          endcase
      default: op = '{kind: OP_R, bg: BG_D0};
    endcase
    return op;
  endfunction

endpackage

// File: rtl/march_addr_gen.sv
// Loadable up/down address counter with a combinational last-address flag.
// Load/step take effect on the next rising edge; no backpressure.
module march_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? ADDR_MAX : '0;
    end else if (step) begin
      addr <= down ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign last = down ? (addr == '0) : (addr == ADDR_MAX);

endmodule

// File: rtl/march_lr_bist.sv
// March LR BIST controller: one SRAM op per cycle, 14*2^ADDR_W cycles per run, no stall input.
// Define BIST_FAIL_LOG_EN to capture the first miscompare on fail_addr/element/expected/actual.
module march_lr_bist
  import march_lr_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_element,
  output logic [DATA_W-1:0] fail_expected,
  output logic [DATA_W-1:0] fail_actual
);

  state_t            state, state_nxt;
  elem_t             elem_q, elem_d;
  logic [1:0]        op_q, op_d;
  logic              fail_q;

  logic              ag_load, ag_load_down, ag_step, ag_down;
  logic [ADDR_W-1:0] addr;
  logic              addr_last;

  op_t               cur_op;
  logic              is_run, op_last, start_acc, rd_miscmp;
  logic [DATA_W-1:0] bg_word;
  elem_t             elem_nxt;

  march_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (ag_load),
    .load_down (ag_load_down),
    .step      (ag_step),
    .down      (ag_down),
    .addr      (addr),
    .last      (addr_last)
  );

  always_comb begin
    state_nxt    = state;
    elem_d       = elem_q;
    op_d         = op_q;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
    start_acc    = 1'b0;
    is_run       = (state == ST_RUN);
    cur_op       = elem_op(elem_q, op_q);
    op_last      = (op_q == elem_last_op(elem_q));
    bg_word      = {DATA_W{cur_op.bg}};
    ag_down      = elem_down(elem_q);
    elem_nxt     = elem_t'(elem_q + 3'd1);

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_acc    = 1'b1;
          state_nxt    = ST_RUN;
          elem_d       = E0;
          op_d         = 2'd0;
          ag_load      = 1'b1;
          ag_load_down = elem_down(E0);
        end
      end
      ST_RUN: begin
        if (!op_last) begin
          op_d = op_q + 2'd1;
        end else begin
          op_d = 2'd0;
          if (!addr_last) begin
            ag_step = 1'b1;
          end else if (elem_q == LAST_ELEM) begin
            state_nxt = ST_DONE;
          end else begin
            // address reloads to the next element's starting end, so no wrap
            elem_d       = elem_nxt;
            ag_load      = 1'b1;
            ag_load_down = elem_down(elem_nxt);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    mem_we    = is_run && (cur_op.kind == OP_W);
    mem_addr  = is_run ? addr : '0;
    mem_wdata = mem_we ? bg_word : '0;
    rd_miscmp = is_run && (cur_op.kind == OP_R) && (mem_rdata != bg_word);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      elem_q <= E0;
      op_q   <= 2'd0;
      fail_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      elem_q <= elem_d;
      op_q   <= op_d;
      if (start_acc) begin
        fail_q <= 1'b0;
      end else if (rd_miscmp) begin
        fail_q <= 1'b1;
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign fail = fail_q;

`ifdef BIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] log_addr;
  logic [2:0]        log_elem;
  logic [DATA_W-1:0] log_exp, log_act;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      log_addr <= '0;
      log_elem <= '0;
      log_exp  <= '0;
      log_act  <= '0;
    end else if (rd_miscmp && !fail_q) begin
      log_addr <= addr;
      log_elem <= elem_q;
      log_exp  <= bg_word;
      log_act  <= mem_rdata;
    end
  end

  assign fail_addr     = log_addr;
  assign fail_element  = log_elem;
  assign fail_expected = log_exp;
  assign fail_actual   = log_act;
`else
  assign fail_addr     = '0;
  assign fail_element  = '0;
  assign fail_expected = '0;
  assign fail_actual   = '0;
`endif

endmodule

// File: tb/tb_march_lr_bist.sv
// Directed bench for march_lr_bist against a 256x4 async-read SRAM model with one stuck-at fault site.
module tb_march_lr_bist;

  localparam int AW = 8;
  localparam int DW = 4;
  localparam int RUN_CYCLES = 3584;

`ifdef BIST_FAIL_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_element;
  logic [DW-1:0] fail_expected, fail_actual;

  march_lr_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .done          (done),
    .fail          (fail),
    .fail_addr     (fail_addr),
    .fail_element  (fail_element),
    .fail_expected (fail_expected),
    .fail_actual   (fail_actual)
  );

  always #5 clk = ~clk;

  // SRAM model; the stuck-at masks apply on the read path at address f_addr
  logic [DW-1:0] mem [0:255];
  logic [AW-1:0] f_addr;
  logic [DW-1:0] sa0, sa1;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign mem_rdata = (mem_addr == f_addr) ? ((mem[mem_addr] & ~sa0) | sa1) : mem[mem_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  // per-run observations
  logic [AW-1:0] o0_addr, o256_addr;
  logic          o0_we, o256_we, o257_we, o0_fail, o0_done;
  logic [DW-1:0] o0_wd, o257_wd;

  task automatic run(input bit mid_start, output int cycles);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cycles = 0;
    while (busy && cycles < 4000) begin
      if (cycles == 0) begin
        o0_addr = mem_addr; o0_we = mem_we; o0_wd = mem_wdata;
        o0_fail = fail;     o0_done = done;
      end
      if (cycles == 256) begin o256_addr = mem_addr; o256_we = mem_we; end
      if (cycles == 257) begin o257_we = mem_we; o257_wd = mem_wdata; end
      start = (mid_start && cycles == 10);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
  endtask

  int cyc;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    f_addr = 8'h00; sa0 = '0; sa1 = '0;
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_faddr", fail_addr, 0);
    chk("rst_felem", fail_element, 0);
    chk("rst_fexp", fail_expected, 0);
    chk("rst_fact", fail_actual, 0);

    // clean run
    run(1'b0, cyc);
    chk("clean_cycles", cyc, RUN_CYCLES);
    chk("clean_done", done, 1);
    chk("clean_fail", fail, 0);
    chk("clean_c0_addr", o0_addr, 8'h00);
    chk("clean_c0_we", o0_we, 1);
    chk("clean_c0_wdata", o0_wd, 4'h0);
    chk("clean_e1_addr", o256_addr, 8'hFF);
    chk("clean_e1_we", o256_we, 0);
    chk("clean_e1_w1_we", o257_we, 1);
    chk("clean_e1_w1_wdata", o257_wd, 4'hF);
    chk("done_we", mem_we, 0);
    chk("done_addr", mem_addr, 0);

    // 0x5A bit2 stuck-at-0: first caught by E2 r1
    f_addr = 8'h5A; sa0 = 4'h4; sa1 = 4'h0;
    run(1'b0, cyc);
    chk("sa0_cycles", cyc, RUN_CYCLES);
    chk("sa0_fail", fail, 1);
    chk("sa0_faddr", fail_addr, LOG ? 8'h5A : 8'h00);
    chk("sa0_felem", fail_element, LOG ? 3'd2 : 3'd0);
    chk("sa0_fexp", fail_expected, LOG ? 4'hF : 4'h0);
    chk("sa0_fact", fail_actual, LOG ? 4'hB : 4'h0);

    // 0x00 bit0 stuck-at-1, start from DONE with fail set, extra start at cycle 10
    f_addr = 8'h00; sa0 = 4'h0; sa1 = 4'h1;
    run(1'b1, cyc);
    chk("rerun_fail_clr", o0_fail, 0);
    chk("rerun_done_clr", o0_done, 0);
    chk("sa1_cycles", cyc, RUN_CYCLES);
    chk("sa1_done", done, 1);
    chk("sa1_fail", fail, 1);
    chk("sa1_faddr", fail_addr, 8'h00);
    chk("sa1_felem", fail_element, LOG ? 3'd1 : 3'd0);
    chk("sa1_fexp", fail_expected, 4'h0);
    chk("sa1_fact", fail_actual, LOG ? 4'h1 : 4'h0);

    // reset at RUN cycle 1000
    sa1 = 4'h0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("mid_busy_up", busy, 1);
    repeat (1000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_fail", fail, 0);

    // rst wins over start
    start = 1'b1;
    @(negedge clk);
    chk("rst_prio_busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    run(1'b0, cyc);
    chk("post_rst_cycles", cyc, RUN_CYCLES);
    chk("post_rst_done", done, 1);
    chk("post_rst_fail", fail, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/march_lr_bist.md
MARCH_LR_BIST -- requirements
Module: march_lr_bist

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the memory address width (256 words).
REQ-002 Parameter DATA_W, default 4, SHALL set the memory word width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL request a test run, sampled only in IDLE or DONE.
REQ-006 mem_addr  output  ADDR_W  SHALL drive the SRAM Address port.
REQ-007 mem_wdata  output  DATA_W  SHALL drive the SRAM data_in port.
REQ-008 mem_we  output  1  SHALL drive the SRAM WE port; 1 = write, 0 = read.
REQ-009 mem_rdata  input  DATA_W  SHALL accept the SRAM data_out port (asynchronous read).
REQ-010 busy  output  1  SHALL be high while the march sequence runs.
REQ-011 done  output  1  SHALL be a level, high from sequence end until the next start or rst.
REQ-012 fail  output  1  SHALL be a sticky flag, set on any read miscompare, cleared on start or rst.
REQ-013 fail_addr  output  ADDR_W, fail_element  output  3, fail_expected and fail_actual  output  DATA_W each SHALL report the first miscompare.

Function
REQ-014 The block SHALL execute March LR with backgrounds D0 = all zeros and D1 = all ones, as six elements:
 - E0 up (w0)
 - E1 down (r0,w1)
 - E2 up (r1,w0,r0,w1)
 - E3 up (r1,w0)
 - E4 up (r0,w1,r1,w0)
 - E5 up (r0)
REQ-015 The FSM SHALL have states IDLE, RUN, DONE: IDLE/DONE --start--> RUN; RUN --last op of E5 at final address--> DONE.
REQ-016 In RUN, exactly one operation SHALL be issued per cycle from registered state; all ops of an element complete at one address before the address steps.
REQ-017 Up order SHALL be 0..255; down order SHALL be 255..0; address SHALL not wrap within an element.
REQ-018 A full run SHALL take exactly 14 x 256 = 3584 RUN cycles; start in IDLE at edge N gives busy=1 and E0 addr 0 in cycle N+1.
REQ-019 For a read op, mem_we=0, and mem_rdata SHALL be compared with the expected background at the closing clock edge of that cycle.
REQ-020 For a write op, mem_we=1, and mem_wdata SHALL hold the background for the whole cycle.
REQ-021 Outside RUN, mem_we SHALL be 0, mem_addr 0 and mem_wdata 0.
REQ-022 A miscompare SHALL set fail and SHALL NOT abort the run.
REQ-023 start asserted while busy SHALL be ignored.
REQ-024 start in DONE SHALL clear done and fail and rerun from E0 addr 0.

Reset
REQ-025 rst SHALL force IDLE, and busy, done, fail, mem_we, mem_addr, mem_wdata, fail_addr, fail_element, fail_expected and fail_actual to 0, including mid-run.
REQ-026 rst SHALL take priority over start in the same cycle.

Configuration
REQ-027 With BIST_FAIL_LOG_EN defined, fail_addr, fail_element, fail_expected and fail_actual SHALL capture the first miscompare only and hold it until start or rst.
REQ-028 Without BIST_FAIL_LOG_EN, those four outputs SHALL be tied to 0; fail behaves identically.

Structure
REQ-029 Package march_lr_pkg SHALL hold the FSM state encoding, element and op encodings, per-element op tables, and the D0/D1 constants.
REQ-030 Sub-module march_addr_gen SHALL implement the loadable up/down address counter with a last-address flag.

Verification
REQ-031 Fault-free 256x4 async-read model, start pulse -> done=1 exactly 3584 cycles after busy rises, fail=0.
REQ-032 Addr 0x5A bit2 stuck-at-0 -> fail=1; fail_addr=0x5A, fail_element=2, fail_expected=4'hF, fail_actual=4'hB.
REQ-033 Addr 0x00 bit0 stuck-at-1 -> fail_element=1, fail_addr=0x00, fail_expected=4'h0, fail_actual=4'h1; run still completes in 3584 cycles.
REQ-034 rst at RUN cycle 1000 -> next cycle busy=0, mem_we=0, done=0; a later start runs a full clean 3584-cycle test.
REQ-035 start pulsed at RUN cycle 10 -> ignored, done still at cycle 3584; start again in DONE clears fail and done.
REQ-036 Build without BIST_FAIL_LOG_EN, fault from REQ-032 -> fail=1, fail_addr=0, fail_actual=0.
